// File: rtl/alu_vector_sequencer.sv
// Stimulus sequencer for the 4-bit ALU under test.
// Walks every {A,B,op} combination once, holding each vector for DWELL cycles.
// vec_idx and vec_valid let downstream trace capture tag each sample.
// A/B/op are slices of the registered index, so every output comes straight from a flop.
module alu_vector_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned OPW   = 2,
    parameter int unsigned DWELL = 1,
    parameter int unsigned TAIL  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pause,
    output logic [WIDTH-1:0]       A,
    output logic [WIDTH-1:0]       B,
    output logic [OPW-1:0]         op,
    output logic                   vec_valid,
    output logic [2*WIDTH+OPW-1:0] vec_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned IdxW   = 2 * WIDTH + OPW;
    localparam int unsigned CntMax = (DWELL > TAIL) ? DWELL : TAIL;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [IdxW-1:0] IdxLast   = '1;
    localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);
    // Only used when TAIL >= 1; the TAIL == 0 case never enters StTail.
    localparam logic [CntW-1:0] TailLast  = CntW'(TAIL - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StRun,
        StTail,
        StDone
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;    // shared dwell/tail counter
    logic [IdxW-1:0] idx_q;
    logic            valid_q;
    logic            busy_q;
    logic            done_q;

    // Sweep FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StPre;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StPre: begin
                    if (!pause) begin
                        if (cnt_q == DwellLast) begin
                            state_q <= StRun;
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (pause) begin
                        valid_q <= 1'b0;
                    end else begin
                        valid_q <= 1'b1;
                        if (cnt_q == DwellLast) begin
                            cnt_q <= '0;
                            // Exit on all-ones so the index never wraps back to zero.
                            if (idx_q == IdxLast) begin
                                valid_q <= 1'b0;
                                if (TAIL == 0) begin
                                    state_q <= StDone;
                                    idx_q   <= '0;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= StTail;
                                end
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StTail: begin
                    if (!pause) begin
                        if (cnt_q == TailLast) begin
                            state_q <= StDone;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign vec_idx   = idx_q;
    assign A         = idx_q[IdxW-1 -: WIDTH];
    assign B         = idx_q[OPW +: WIDTH];
    assign op        = idx_q[OPW-1:0];
    assign vec_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Directed bench for alu_vector_sequencer: one instance with DWELL=1/TAIL=5,
// one with DWELL=3/TAIL=0. Outputs are sampled on the falling edge.
module tb_alu_vector_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, start1, pause1;
    logic [3:0] a1, b1;
    logic [1:0] op1;
    logic       valid1, busy1, done1;
    logic [9:0] idx1;

    logic       rst3, start3, pause3;
    logic [3:0] a3, b3;
    logic [1:0] op3;
    logic       valid3, busy3, done3;
    logic [9:0] idx3;

    alu_vector_sequencer #(.WIDTH(4), .OPW(2), .DWELL(1), .TAIL(5)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .pause(pause1),
        .A(a1), .B(b1), .op(op1), .vec_valid(valid1), .vec_idx(idx1),
        .busy(busy1), .done(done1)
    );

    alu_vector_sequencer #(.WIDTH(4), .OPW(2), .DWELL(3), .TAIL(0)) u3 (
        .clk(clk), .rst(rst3), .start(start3), .pause(pause3),
        .A(a3), .B(b3), .op(op3), .vec_valid(valid3), .vec_idx(idx3),
        .busy(busy3), .done(done3)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         t;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic       valid;
        logic [9:0] idx;
        logic       busy;
        logic       done;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] o, input logic v,
                                       input logic [9:0] i, input logic bz, input logic d);
        return {9'd0, a, b, o, v, i, bz, d};
    endfunction

    function automatic logic [31:0] pack1();
        return pk(a1, b1, op1, valid1, idx1, busy1, done1);
    endfunction

    function automatic logic [31:0] pack3();
        return pk(a3, b3, op3, valid3, idx3, busy3, done3);
    endfunction

    task automatic wait_idx1(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (valid1 && idx1 == 10'(target)) ok = 1'b1;
        end
    endtask

    initial begin
        int         busy_n, valid_n, done_n, occ100, low100, pause_left;
        bit         ok, paused;
        logic [9:0] exp_k;
        logic [9:0] kk;
        logic [31:0] e;

        // t = cycle index after the start edge
        tbl[0]  = '{0,    4'd0,  4'd0,  2'd0, 1'b0, 10'd0,    1'b1, 1'b0};
        tbl[1]  = '{1,    4'd0,  4'd0,  2'd0, 1'b1, 10'd0,    1'b1, 1'b0};
        tbl[2]  = '{2,    4'd0,  4'd0,  2'd1, 1'b1, 10'd1,    1'b1, 1'b0};
        tbl[3]  = '{3,    4'd0,  4'd0,  2'd2, 1'b1, 10'd2,    1'b1, 1'b0};
        tbl[4]  = '{4,    4'd0,  4'd0,  2'd3, 1'b1, 10'd3,    1'b1, 1'b0};
        tbl[5]  = '{5,    4'd0,  4'd1,  2'd0, 1'b1, 10'd4,    1'b1, 1'b0};
        tbl[6]  = '{301,  4'd4,  4'd11, 2'd0, 1'b1, 10'd300,  1'b1, 1'b0};
        tbl[7]  = '{302,  4'd4,  4'd11, 2'd1, 1'b1, 10'd301,  1'b1, 1'b0};
        tbl[8]  = '{1024, 4'd15, 4'd15, 2'd3, 1'b1, 10'd1023, 1'b1, 1'b0};
        tbl[9]  = '{1025, 4'd15, 4'd15, 2'd3, 1'b0, 10'd1023, 1'b1, 1'b0};
        tbl[10] = '{1029, 4'd15, 4'd15, 2'd3, 1'b0, 10'd1023, 1'b1, 1'b0};
        tbl[11] = '{1030, 4'd0,  4'd0,  2'd0, 1'b0, 10'd0,    1'b0, 1'b1};
        tbl[12] = '{1031, 4'd0,  4'd0,  2'd0, 1'b0, 10'd0,    1'b0, 1'b0};
        tbl[13] = '{1040, 4'd0,  4'd0,  2'd0, 1'b0, 10'd0,    1'b0, 1'b0};

        rst1 = 1'b1; start1 = 1'b0; pause1 = 1'b0;
        rst3 = 1'b1; start3 = 1'b0; pause3 = 1'b0;
        repeat (3) @(negedge clk);
        // start and pause high during reset must not matter
        start1 = 1'b1; pause1 = 1'b1;
        @(negedge clk);
        chk("reset u1", pack1(), 32'd0);
        chk("reset u3", pack3(), 32'd0);
        rst1 = 1'b0; rst3 = 1'b0; start1 = 1'b0; pause1 = 1'b0;
        @(negedge clk);
        chk("idle u1", pack1(), 32'd0);

        // Full sweep, DWELL=1 TAIL=5, with stray starts mid-sweep and on done
        busy_n = 0; valid_n = 0; done_n = 0; exp_k = '0;
        start1 = 1'b1;
        for (int t = 0; t <= 1040; t++) begin
            @(negedge clk);
            for (int i = 0; i < NV; i++) begin
                if (tbl[i].t == t) begin
                    chk($sformatf("tbl t=%0d", t), pack1(),
                        pk(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].valid, tbl[i].idx,
                           tbl[i].busy, tbl[i].done));
                end
            end
            if (busy1) busy_n++;
            if (done1) done_n++;
            if (valid1) begin
                valid_n++;
                chk($sformatf("order idx t=%0d", t), 32'(idx1), 32'(exp_k));
                chk($sformatf("order abop t=%0d", t), 32'({a1, b1, op1}), 32'(exp_k));
                exp_k = exp_k + 10'd1;
            end
            start1 = (t == 300) || (t == 1030);
        end
        start1 = 1'b0;
        chk("sweep busy cycles", 32'(busy_n), 32'd1030);
        chk("sweep valid cycles", 32'(valid_n), 32'd1024);
        chk("sweep done pulses", 32'(done_n), 32'd1);

        // Pause for 10 cycles while vec_idx = 100
        busy_n = 0; valid_n = 0; done_n = 0; exp_k = '0;
        occ100 = 0; low100 = 0; pause_left = 0; paused = 1'b0;
        start1 = 1'b1;
        for (int t = 0; t < 1100; t++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (busy1) busy_n++;
            if (done1) done_n++;
            if (idx1 == 10'd100) begin
                occ100++;
                if (!valid1) low100++;
            end
            if (valid1) begin
                valid_n++;
                chk($sformatf("pause order t=%0d", t), 32'(idx1), 32'(exp_k));
                exp_k = exp_k + 10'd1;
            end
            if (pause_left > 0) begin
                pause_left--;
                if (pause_left == 0) pause1 = 1'b0;
            end
            if (valid1 && idx1 == 10'd100 && !paused) begin
                pause1 = 1'b1;
                pause_left = 10;
                paused = 1'b1;
            end
        end
        chk("pause idx100 cycles", 32'(occ100), 32'd11);
        chk("pause idx100 invalid", 32'(low100), 32'd10);
        chk("pause valid cycles", 32'(valid_n), 32'd1024);
        chk("pause busy cycles", 32'(busy_n), 32'd1040);
        chk("pause done pulses", 32'(done_n), 32'd1);

        // Reset at vec_idx = 500 aborts the sweep
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_idx1(500, ok);
        chk("reach idx500", 32'(ok), 32'd1);
        rst1 = 1'b1;
        @(negedge clk);
        chk("abort reset", pack1(), 32'd0);
        rst1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("abort quiet %0d", i), pack1(), 32'd0);
        end
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("restart pre", pack1(), pk(4'd0, 4'd0, 2'd0, 1'b0, 10'd0, 1'b1, 1'b0));
        @(negedge clk);
        chk("restart v0", pack1(), pk(4'd0, 4'd0, 2'd0, 1'b1, 10'd0, 1'b1, 1'b0));
        @(negedge clk);
        chk("restart v1", pack1(), pk(4'd0, 4'd0, 2'd1, 1'b1, 10'd1, 1'b1, 1'b0));

        // DWELL=3 TAIL=0 trace against a cycle model
        start3 = 1'b1;
        for (int t = 0; t < 3090; t++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (t < 3) begin
                e = pk(4'd0, 4'd0, 2'd0, 1'b0, 10'd0, 1'b1, 1'b0);
            end else if (t < 3075) begin
                kk = 10'((t - 3) / 3);
                e = pk(kk[9:6], kk[5:2], kk[1:0], 1'b1, kk, 1'b1, 1'b0);
            end else if (t == 3075) begin
                e = pk(4'd0, 4'd0, 2'd0, 1'b0, 10'd0, 1'b0, 1'b1);
            end else begin
                e = 32'd0;
            end
            chk($sformatf("dwell3 t=%0d", t), pack3(), e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
